mod_fixed_mul_pipe: RTL

//   Pipelined signed fixed-point multiplier with valid/ready streaming handshake.

---
 rtl/mod_fixed_mul_pipe_pkg.sv | 15 +
 rtl/mod_fixed_mul_pipe_if.sv | 30 +++
 rtl/mod_fixed_mul_pipe_round_sat.sv | 35 +++
 rtl/mod_fixed_mul_pipe.sv | 87 ++++++++
 4 files changed

// File: rtl/mod_fixed_mul_pipe_pkg.sv
// Fixed-point helpers shared by the pipelined multiplier and its rounding stage.
// Saturation limits are returned as longint, so widths up to 63 bits are supported.
package pkg_fixed;

  typedef enum logic {FX_TRUNC, FX_ROUND} fx_round_t;

  function automatic longint fx_max(input int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  function automatic longint fx_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/mod_fixed_mul_pipe_if.sv
// Streaming handshake bundle for the fixed-point multiplier.
// The slave side is the multiplier; the master side is the data source and sink.
interface mod_fixed_mul_pipe_if #(
  parameter int W         = 32,
  parameter int TAG_WIDTH = 4
);
  logic [W-1:0]         i_a;
  logic [W-1:0]         i_b;
  logic [TAG_WIDTH-1:0] i_tag;
  logic                 i_round;
  logic                 i_valid;
  logic                 o_in_ready;
  logic [W-1:0]         o_out;
  logic [TAG_WIDTH-1:0] o_tag;
  logic                 o_sat;
  logic                 o_valid;
  logic                 i_out_ready;
  logic                 o_sat_sticky;
  logic                 i_sat_clr;

  modport slave (
    input  i_a, i_b, i_tag, i_round, i_valid, i_out_ready, i_sat_clr,
    output o_in_ready, o_out, o_tag, o_sat, o_valid, o_sat_sticky
  );

  modport master (
    output i_a, i_b, i_tag, i_round, i_valid, i_out_ready, i_sat_clr,
    input  o_in_ready, o_out, o_tag, o_sat, o_valid, o_sat_sticky
  );
endinterface

// File: rtl/mod_fixed_mul_pipe_round_sat.sv
// Combinational rounding and saturation of a 2W-bit Q product back to W bits.
// Rounding is done at 2W+1 bits, so adding the half-LSB can never wrap.
module mod_fixed_round_sat
  import pkg_fixed::*;
#(
  parameter int W = 32,
  parameter int P = 8
) (
  input  logic signed [2*W-1:0] prod,
  input  fx_round_t             mode,
  output logic        [W-1:0]   res,
  output logic                  sat
);
  localparam int HS = (P > 0) ? P - 1 : 0;
  localparam logic signed [2*W:0] HALF    = (P > 0) ? ((2*W+1)'(1) <<< HS) : '0;
  localparam logic signed [2*W:0] MAX_EXT = (2*W+1)'(fx_max(W));
  localparam logic signed [2*W:0] MIN_EXT = (2*W+1)'(fx_min(W));

  logic signed [2*W:0] sum;
  logic signed [2*W:0] r;

  always_comb begin
    sum = {prod[2*W-1], prod} + ((mode == FX_ROUND) ? HALF : '0);
    r   = sum >>> P;
    res = r[W-1:0];
    sat = 1'b0;
    if (r > MAX_EXT) begin
      res = MAX_EXT[W-1:0];
      sat = 1'b1;
    end else if (r < MIN_EXT) begin
      res = MIN_EXT[W-1:0];
      sat = 1'b1;
    end
  end
endmodule

// File: rtl/mod_fixed_mul_pipe.sv
// Three-stage signed Q-format multiplier with valid/ready streaming and a sticky clamp flag.
// A downstream stall freezes every stage at once; bubbles stay in place.
module mod_fixed_mul_pipe
  import pkg_fixed::*;
#(
  parameter int INPUT_WIDTH = 32,
  parameter int INPUT_POINT = 8,
  parameter int TAG_WIDTH   = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  mod_fixed_mul_pipe_if.slave bus
);
  localparam int W = INPUT_WIDTH;

  logic                  en;
  logic                  v0, v1;
  logic signed [W-1:0]   a0, b0;
  logic [TAG_WIDTH-1:0]  tag0, tag1;
  fx_round_t             rnd0, rnd1;
  logic signed [2*W-1:0] prod1;
  logic [W-1:0]          rs_res;
  logic                  rs_sat;
  logic                  sat_set;

  assign en             = ~(bus.o_valid & ~bus.i_out_ready);
  assign bus.o_in_ready = en;
  assign sat_set        = bus.o_valid & bus.i_out_ready & bus.o_sat;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v0   <= 1'b0;
      a0   <= '0;
      b0   <= '0;
      tag0 <= '0;
      rnd0 <= FX_TRUNC;
    end else if (en) begin
      v0   <= bus.i_valid;
      a0   <= bus.i_a;
      b0   <= bus.i_b;
      tag0 <= bus.i_tag;
      rnd0 <= fx_round_t'(bus.i_round);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1    <= 1'b0;
      prod1 <= '0;
      tag1  <= '0;
      rnd1  <= FX_TRUNC;
    end else if (en) begin
      v1    <= v0;
      prod1 <= (2*W)'(a0) * (2*W)'(b0);
      tag1  <= tag0;
      rnd1  <= rnd0;
    end
  end

  mod_fixed_round_sat #(.W(W), .P(INPUT_POINT)) u_round_sat (
    .prod (prod1),
    .mode (rnd1),
    .res  (rs_res),
    .sat  (rs_sat)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_valid <= 1'b0;
      bus.o_out   <= '0;
      bus.o_tag   <= '0;
      bus.o_sat   <= 1'b0;
    end else if (en) begin
      bus.o_valid <= v1;
      bus.o_out   <= rs_res;
      bus.o_tag   <= tag1;
      bus.o_sat   <= rs_sat;
    end
  end

  // Set wins over clear when a clamped beat leaves in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)              bus.o_sat_sticky <= 1'b0;
    else if (sat_set)       bus.o_sat_sticky <= 1'b1;
    else if (bus.i_sat_clr) bus.o_sat_sticky <= 1'b0;
  end
endmodule
